// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory stage SRAM controller: FSM state
// encoding, the default data-segment base and the address helper.
package mem_stage_sram_ctrl_pkg;

  // Access sequencer states; other stages decode these for freeze logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Byte address that maps onto SRAM half-word 0.
  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

  // Width of the per-beat wait-state counter (WAIT_CYCLES is 0..7).
  localparam int BEAT_CNT_W = 3;

  // Data-segment relative byte address; wraps modulo 2^32.
  function automatic logic [31:0] to_phys(input logic [31:0] addr,
                                          input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_beat_timer.sv
// Wait-state counter for one SRAM half-word beat. Counts up while enabled,
// clears on request, and flags the last cycle of the beat both for the
// current cycle and for the cycle after the coming clock edge.
module sram_beat_timer
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last,
  output logic o_last_next
);

  localparam logic [BEAT_CNT_W-1:0] LAST_CNT = BEAT_CNT_W'(WAIT_CYCLES);

  logic [BEAT_CNT_W-1:0] r_cnt;
  logic [BEAT_CNT_W-1:0] w_cnt_next;

  // Next count: clear has priority over counting.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_last      = (r_cnt == LAST_CNT);
  assign o_last_next = (w_cnt_next == LAST_CNT);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage controller: performs 32-bit loads/stores over a 16-bit
// asynchronous SRAM as a low then a high half-word beat, each stretched by
// WAIT_CYCLES wait states, and holds the pipeline via ready meanwhile.
// SRAM pins are registered from the next-state view so they are glitch-free
// and line up with the state they belong to.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int          WAIT_CYCLES = 1,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i
);

  mem_state_e r_state;
  mem_state_e w_state_next;

  logic               w_req;
  logic               w_is_store;
  logic               w_is_load;
  logic               w_in_beat;
  logic               w_next_in_beat;
  logic               w_next_is_hi;
  logic               w_clr;
  logic               w_last;
  logic               w_last_next;
  logic [31:0]        w_phys;
  logic [SRAM_AW-2:0] w_word;
  logic               w_unused;

  logic [31:0]        r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic               r_sram_we_n;
  logic [15:0]        r_sram_dq_o;
  logic               r_sram_dq_oe;

  logic [SRAM_AW-1:0] w_addr_next;
  logic               w_we_n_next;
  logic [15:0]        w_dq_o_next;
  logic               w_oe_next;

  // A store wins when both enables are set.
  assign w_req      = rd_en | wr_en;
  assign w_is_store = wr_en;
  assign w_is_load  = rd_en & ~wr_en;

  // Word-aligned translation; byte offset and upper bits are not used.
  assign w_phys   = to_phys(address, DATA_BASE);
  assign w_word   = w_phys[SRAM_AW:2];
  assign w_unused = ^{w_phys[31:SRAM_AW+1], w_phys[1:0]};

  assign w_in_beat      = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_next_in_beat = (w_state_next == ST_LO) || (w_state_next == ST_HI);
  assign w_next_is_hi   = (w_state_next == ST_HI);

  // The counter restarts on every state change and idles outside beats.
  assign w_clr = ~w_in_beat | (w_state_next != r_state);

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_en        (w_in_beat),
    .o_last      (w_last),
    .o_last_next (w_last_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping the request mid-beat aborts to IDLE.
  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_next = ST_LO;
      ST_LO: begin
        if (!w_req)      w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_HI;
      end
      ST_HI: begin
        if (!w_req)      w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // SRAM pin values for the cycle after the coming edge. The write strobe
  // is released in the last cycle of a beat for address/data hold, except
  // with zero wait states where the beat is a single strobed cycle.
  always_comb begin
    w_addr_next = r_sram_addr;
    w_dq_o_next = r_sram_dq_o;
    w_we_n_next = 1'b1;
    w_oe_next   = 1'b0;
    if (w_next_in_beat) begin
      w_addr_next = {w_word, w_next_is_hi};
      if (w_is_store) begin
        w_oe_next   = 1'b1;
        w_dq_o_next = w_next_is_hi ? write_data[31:16] : write_data[15:0];
        w_we_n_next = ~((WAIT_CYCLES == 0) | ~w_last_next);
      end
    end
  end

  // Registered SRAM pins; reset forces them idle even mid write beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr  <= '0;
      r_sram_we_n  <= 1'b1;
      r_sram_dq_o  <= '0;
      r_sram_dq_oe <= 1'b0;
    end else begin
      r_sram_addr  <= w_addr_next;
      r_sram_we_n  <= w_we_n_next;
      r_sram_dq_o  <= w_dq_o_next;
      r_sram_dq_oe <= w_oe_next;
    end
  end

  // Load capture at the end of each beat; stores never touch read_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (w_is_load && w_last) begin
      if (r_state == ST_LO) begin
        r_read_data[15:0] <= sram_dq_i;
      end else if (r_state == ST_HI) begin
        r_read_data[31:16] <= sram_dq_i;
      end
    end
  end

  assign ready      = ~w_req | (r_state == ST_DONE);
  assign read_data  = r_read_data;
  assign sram_addr  = r_sram_addr;
  assign sram_we_n  = r_sram_we_n;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_sram_dq_oe;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench: three controllers with 0, 1 and 3 wait states, each on its own
// half-word SRAM model. A word-level reference memory predicts each access;
// a monitor scores every completion against the queued expectation.
module tb_mem_stage_sram_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en      [NI];
  logic        wr_en      [NI];
  logic [31:0] address    [NI];
  logic [31:0] write_data [NI];
  logic [31:0] read_data  [NI];
  logic        ready      [NI];
  logic [17:0] sram_addr  [NI];
  logic        sram_we_n  [NI];
  logic [15:0] sram_dq_o  [NI];
  logic        sram_dq_oe [NI];
  logic [15:0] sram_dq_i  [NI];

  function automatic int w_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_stage_sram_ctrl #(
      .DATA_BASE   (32'd1024),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .SRAM_AW     (18)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en[g]),
      .wr_en      (wr_en[g]),
      .address    (address[g]),
      .write_data (write_data[g]),
      .read_data  (read_data[g]),
      .ready      (ready[g]),
      .sram_addr  (sram_addr[g]),
      .sram_we_n  (sram_we_n[g]),
      .sram_dq_o  (sram_dq_o[g]),
      .sram_dq_oe (sram_dq_oe[g]),
      .sram_dq_i  (sram_dq_i[g])
    );
  end

  // Asynchronous SRAM models (256 half-words each); first cycle clears and
  // preloads 16'h5678 / 16'h1234 at half-words 2 / 3 of instance 1.
  logic [15:0] sram_mem [NI][256];
  logic        preload_done = 1'b0;

  always @(posedge clk) begin
    if (!preload_done) begin
      for (int k = 0; k < NI; k++)
        for (int i = 0; i < 256; i++) sram_mem[k][i] <= 16'h0000;
      sram_mem[1][2] <= 16'h5678;
      sram_mem[1][3] <= 16'h1234;
      preload_done   <= 1'b1;
    end else if (!rst) begin
      for (int k = 0; k < NI; k++)
        if (!sram_we_n[k]) sram_mem[k][sram_addr[k][7:0]] <= sram_dq_o[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) sram_dq_i[k] = sram_mem[k][sram_addr[k][7:0]];
  end

  // Word-level reference model.
  logic [31:0] ref_mem  [NI][128];
  logic [31:0] ref_last [NI];

  typedef struct {
    int          k;
    logic [31:0] data;
    int          low_len;
    int          we_low;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures each access and scores it when ready rises.
  logic mon_en  [NI];
  int   low_cnt [NI];
  int   we_low  [NI];
  int   bad_pin [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!mon_en[k] || rst) begin
        low_cnt[k] = 0;
        we_low[k]  = 0;
        bad_pin[k] = 0;
      end else if (rd_en[k] | wr_en[k]) begin
        if (!ready[k]) begin
          low_cnt[k]++;
          if (!sram_we_n[k]) we_low[k]++;
          if ((!wr_en[k] && (sram_dq_oe[k] || !sram_we_n[k])) ||
              (!sram_we_n[k] && !sram_dq_oe[k])) bad_pin[k]++;
        end else begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: inst %0d got done expected none", k);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_inst", 32'(k), 32'(e.k));
            check("read_data", read_data[k], e.data);
            check("ready_low_len", 32'(low_cnt[k]), 32'(e.low_len));
            check("we_low_cycles", 32'(we_low[k]), 32'(e.we_low));
            check("pin_protocol", 32'(bad_pin[k]), 32'd0);
            check("done_pins", {30'd0, sram_we_n[k], sram_dq_oe[k]}, 32'd2);
          end
          low_cnt[k] = 0;
          we_low[k]  = 0;
          bad_pin[k] = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that
  // completes the access.
  task automatic wait_done(input int k);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (ready[k]) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: inst %0d ready still 0 expected 1 within 40 cycles", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int k, input logic rd, input logic wr,
                           input logic [6:0] word, input logic [31:0] wdata,
                           input int gap);
    exp_t e;
    int   w = w_of(k);
    e.k       = k;
    e.low_len = 2 * w + 3;
    if (wr) begin
      ref_mem[k][word] = wdata;
      e.data   = ref_last[k];
      e.we_low = (w == 0) ? 2 : 2 * w;
    end else begin
      ref_last[k] = ref_mem[k][word];
      e.data   = ref_last[k];
      e.we_low = 0;
    end
    sb_q.push_back(e);
    rd_en[k]      = rd;
    wr_en[k]      = wr;
    address[k]    = 32'd1024 + 32'(word) * 32'd4;
    write_data[k] = wdata;
    wait_done(k);
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] d;
    for (int k = 0; k < NI; k++) begin
      rd_en[k] = 1'b0; wr_en[k] = 1'b0; address[k] = '0; write_data[k] = '0;
      mon_en[k] = 1'b0; ref_last[k] = '0;
      for (int i = 0; i < 128; i++) ref_mem[k][i] = '0;
    end
    ref_mem[1][1] = 32'h12345678;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", {31'd0, ready[k]}, 32'd1);
      check("rst_we_n", {31'd0, sram_we_n[k]}, 32'd1);
      check("rst_oe", {31'd0, sram_dq_oe[k]}, 32'd0);
      check("rst_addr", {14'd0, sram_addr[k]}, 32'd0);
      check("rst_dq_o", {16'd0, sram_dq_o[k]}, 32'd0);
      check("rst_read_data", read_data[k], 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < NI; k++) mon_en[k] = 1'b1;

    // Directed accesses on the one-wait-state instance.
    do_access(1, 1'b0, 1'b1, 7'd0, 32'hDEADBEEF, 1);
    check("store_lo_half", {16'd0, sram_mem[1][0]}, 32'h0000BEEF);
    check("store_hi_half", {16'd0, sram_mem[1][1]}, 32'h0000DEAD);
    do_access(1, 1'b1, 1'b0, 7'd1, 32'd0, 1);
    check("load_hold", read_data[1], 32'h12345678);
    do_access(1, 1'b0, 1'b1, 7'd2, 32'hC0FFEE11, 0);
    do_access(1, 1'b1, 1'b0, 7'd2, 32'd0, 1);
    do_access(1, 1'b1, 1'b1, 7'd3, 32'hA5A50F0F, 1);
    check("both_keeps_read", read_data[1], 32'hC0FFEE11);
    do_access(1, 1'b1, 1'b0, 7'd3, 32'd0, 1);

    // Randomized traffic on each instance, with random idle gaps.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 30; i++) begin
        int op;
        op = $urandom_range(0, 2);
        do_access(k, op != 1, op != 0, 7'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 2));
      end
    end

    // Reset during the high beat of a store, request left asserted.
    mon_en[1] = 1'b0;
    d = 32'h13579BDF;
    wr_en[1] = 1'b1; address[1] = 32'd1024 + 32'd20; write_data[1] = d;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("hi_beat_addr", {14'd0, sram_addr[1]}, 32'd11);
    check("hi_beat_we_n", {31'd0, sram_we_n[1]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_we_n", {31'd0, sram_we_n[1]}, 32'd1);
    check("midrst_oe", {31'd0, sram_dq_oe[1]}, 32'd0);
    check("midrst_read_data", read_data[1], 32'd0);
    check("midrst_addr", {14'd0, sram_addr[1]}, 32'd0);
    check("midrst_ready", {31'd0, ready[1]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("restart_oe", {31'd0, sram_dq_oe[1]}, 32'd1);
    check("restart_addr", {14'd0, sram_addr[1]}, 32'd10);
    check("restart_dq_o", {16'd0, sram_dq_o[1]}, {16'd0, d[15:0]});
    wait_done(1);
    wr_en[1] = 1'b0;
    ref_mem[1][5] = d;
    for (int k = 0; k < NI; k++) ref_last[k] = '0;
    mon_en[1] = 1'b1;
    do_access(0, 1'b0, 1'b1, 7'd9, 32'h0BADF00D, 1);
    do_access(1, 1'b1, 1'b0, 7'd5, 32'd0, 1);
    do_access(2, 1'b1, 1'b0, 7'd9, 32'd0, 1);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
